// File: rtl/lu_lsu_responder.sv
// Memory-side responder for the load/store port: requests queue in order in a small FIFO
// and execute one at a time against a local synchronous RAM with a fixed load latency.
module lu_lsu_responder #(
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned DATA_SIZE  = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 LSVLD,
    input  logic                 LREQ,
    input  logic                 SREQ,
    input  logic [ADDR_SIZE-1:0] LSADDR,
    input  logic [DATA_SIZE-1:0] SDATA,
    output logic                 LSRDY,
    output logic [DATA_SIZE-1:0] LDATA,
    output logic                 LDRDY,
    output logic                 ERR
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned EntW = 1 + ADDR_SIZE + DATA_SIZE;
    localparam int unsigned RamDepth = 2 ** ADDR_SIZE;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    // Request FIFO: entry = {is_store, addr, data}
    logic [EntW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    logic [DATA_SIZE-1:0] ram [RamDepth];

    state_e               state;
    logic [LatW-1:0]      cnt;
    logic [ADDR_SIZE-1:0] ld_addr;

    logic                 req_ok;
    logic                 req_bad;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [EntW-1:0]      head;
    logic                 head_store;
    logic [ADDR_SIZE-1:0] head_addr;
    logic [DATA_SIZE-1:0] head_data;
    logic                 ram_we;

    assign req_ok     = LREQ ^ SREQ;
    assign req_bad    = LREQ & SREQ;
    assign fifo_empty = (count == '0);
    assign LSRDY      = (count != CntW'(FIFO_DEPTH));
    assign push       = LSVLD & LSRDY & req_ok;
    assign pop        = (state == StIdle) & ~fifo_empty;

    assign head       = fifo_mem[rd_ptr];
    assign head_store = head[EntW-1];
    assign head_addr  = head[EntW-2 -: ADDR_SIZE];
    assign head_data  = head[DATA_SIZE-1:0];

    // Reset wins over a pending pop, so queued stores are dropped rather than performed.
    assign ram_we     = pop & head_store & ~rst;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr] <= {SREQ, LSADDR, SDATA};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // RAM is deliberately outside reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[head_addr] <= head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            ld_addr <= '0;
            LDATA   <= '0;
            LDRDY   <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            LDRDY <= 1'b0;
            ERR   <= LSVLD & LSRDY & req_bad;
            case (state)
                StIdle: begin
                    if (!fifo_empty && !head_store) begin
                        ld_addr <= head_addr;
                        cnt     <= LatW'(RD_LATENCY - 1);
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (cnt == '0) begin
                        LDATA <= ram[ld_addr];
                        LDRDY <= 1'b1;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - LatW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_lsu_responder.sv
// Bench for lu_lsu_responder: directed scenarios plus random traffic, checked against a
// transaction-level model (RAM array updated at accept time, queue of expected load data).
module tb_lu_lsu_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        LSVLD = 1'b0;
    logic        LREQ = 1'b0;
    logic        SREQ = 1'b0;
    logic [7:0]  LSADDR = '0;
    logic [15:0] SDATA = '0;
    logic        LSRDY, LDRDY, ERR;
    logic [15:0] LDATA;
    logic        LSRDY1, LDRDY1, ERR1;
    logic [15:0] LDATA1;

    lu_lsu_responder u_dut (
        .clk(clk), .rst(rst), .LSVLD(LSVLD), .LREQ(LREQ), .SREQ(SREQ),
        .LSADDR(LSADDR), .SDATA(SDATA), .LSRDY(LSRDY), .LDATA(LDATA),
        .LDRDY(LDRDY), .ERR(ERR)
    );

    lu_lsu_responder #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .LSVLD(LSVLD), .LREQ(LREQ), .SREQ(SREQ),
        .LSADDR(LSADDR), .SDATA(SDATA), .LSRDY(LSRDY1), .LDATA(LDATA1),
        .LDRDY(LDRDY1), .ERR(ERR1)
    );

    always #5 clk = ~clk;

    int          nchk = 0;
    int          npass = 0;
    int          edge_no = 0;
    logic [15:0] mram [256];
    logic [15:0] expq [$];
    int          ld_edges [$];
    int          ld1_edge;
    logic [15:0] ld1_data;
    logic        saw_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive, update model on acceptance, then check ERR and any returned load.
    task automatic step(input logic v, input logic l, input logic s,
                        input logic [7:0] a, input logic [15:0] d);
        logic acc;
        logic err_exp;
        LSVLD = v; LREQ = l; SREQ = s; LSADDR = a; SDATA = d;
        acc     = v && LSRDY && !rst;
        err_exp = acc && l && s;
        if (!LSRDY) saw_full = 1'b1;
        if (acc && (l ^ s)) begin
            if (s) mram[a] = d;
            else   expq.push_back(mram[a]);
        end
        @(posedge clk);
        edge_no++;
        #1;
        chk("err", {31'd0, ERR}, {31'd0, err_exp});
        if (LDRDY) begin
            ld_edges.push_back(edge_no);
            if (expq.size() == 0) chk("ldrdy_unexpected", {31'd0, LDRDY}, 32'd0);
            else                  chk("ldata", {16'd0, LDATA}, {16'd0, expq.pop_front()});
        end
        if (LDRDY1) begin
            ld1_edge = edge_no;
            ld1_data = LDATA1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && expq.size() != 0; i++) idle(1);
        chk("drain_empty", expq.size(), 0);
        idle(2);
    endtask

    task automatic do_reset(input string tag);
        expq.delete();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk({tag, "_lsrdy"}, {31'd0, LSRDY}, 32'd1);
        chk({tag, "_ldrdy"}, {31'd0, LDRDY}, 32'd0);
        chk({tag, "_ldata"}, {16'd0, LDATA}, 32'd0);
        chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
        chk({tag, "_lsrdy1"}, {31'd0, LSRDY1}, 32'd1);
    endtask

    initial begin
        int acc_edge;
        int i;
        int guard;
        logic [1:0] op;
        saw_full = 1'b0;
        ld1_edge = -1;
        ld1_data = '0;

        do_reset("rst0");

        // Store then load the same word; LDRDY exactly RD_LATENCY+1 edges after accept.
        ld_edges.delete();
        step(1'b1, 1'b0, 1'b1, 8'h10, 16'hBEEF);
        step(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
        acc_edge = edge_no;
        drain();
        chk("t2_npulse", ld_edges.size(), 1);
        if (ld_edges.size() > 0) chk("t2_latency", ld_edges[0], acc_edge + 3);
        chk("t2_ldata_hold", {16'd0, LDATA}, 32'h0000BEEF);

        // Preload 0..7, then six back-to-back loads must fill the FIFO and return in order.
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 8'(k), 16'h0100 + 16'(k));
        idle(3);
        ld_edges.delete();
        saw_full = 1'b0;
        i = 0;
        guard = 0;
        while (i < 6 && guard < 40) begin
            if (LSRDY) begin
                step(1'b1, 1'b1, 1'b0, 8'(i), 16'h0000);
                i++;
            end else begin
                step(1'b1, 1'b1, 1'b0, 8'(i), 16'h0000);
            end
            guard++;
        end
        drain();
        chk("t3_saw_full", {31'd0, saw_full}, 32'd1);
        chk("t3_npulse", ld_edges.size(), 6);
        for (int k = 1; k < ld_edges.size(); k++) chk("t3_spacing", ld_edges[k] - ld_edges[k-1], 3);
        chk("t3_last", {16'd0, LDATA}, 32'h00000105);

        // Random mixed traffic on a small address window to force ordering hazards.
        for (int k = 0; k < 200; k++) begin
            op = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 3) != 0), (op == 2'd0 || op == 2'd1 || op == 2'd3),
                 (op == 2'd2 || op == 2'd3), 8'($urandom_range(0, 7)), 16'($urandom));
        end
        drain();

        // Both qualifiers set: dropped with a one-cycle ERR, RAM untouched.
        step(1'b1, 1'b1, 1'b1, 8'h10, 16'h1234);
        chk("t4_err_pulse", {31'd0, ERR}, 32'd1);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
        drain();
        chk("t4_ldata", {16'd0, LDATA}, 32'h0000BEEF);

        // Reset in the middle of a burst of loads.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 7)), 16'h0);
        do_reset("rst_mid");
        idle(8);

        // Load accepted, reset on the very next edge: it must never complete.
        step(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
        do_reset("rst_inflight");
        idle(8);
        step(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
        drain();
        chk("t5_ldata", {16'd0, LDATA}, 32'h0000BEEF);

        // Top address; latency-1 instance completes one edge sooner.
        ld_edges.delete();
        ld1_edge = -1;
        step(1'b1, 1'b0, 1'b1, 8'hFF, 16'h00AA);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 16'h0000);
        acc_edge = edge_no;
        drain();
        chk("t6_lat1_edge", ld1_edge, acc_edge + 2);
        chk("t6_lat1_data", {16'd0, ld1_data}, 32'h000000AA);
        chk("t6_err1", {31'd0, ERR1}, 32'd0);
        chk("t6_npulse", ld_edges.size(), 1);
        if (ld_edges.size() > 0) chk("t6_lat2_edge", ld_edges[0], acc_edge + 3);
        chk("t6_ldata", {16'd0, LDATA}, 32'h000000AA);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/lu_lsu_responder.md
Name: lu_lsu_responder

Overview:
Memory-side responder for the processor load/store port. It accepts LSVLD-qualified load (LREQ) and store (SREQ) requests and queues them in order in a request FIFO. Requests execute against a local synchronous data RAM. Load data returns on LDATA, qualified by a one-cycle LDRDY pulse, after a configurable access latency. It sits between the processor's load/store stage and data storage, and provides back-pressure through LSRDY.

Parameters:
ADDR_SIZE, 8, LSADDR width; RAM depth is 2**ADDR_SIZE words.
DATA_SIZE, 16, width of SDATA, LDATA and RAM words.
FIFO_DEPTH, 4, request FIFO entries; power of 2, >=2.
RD_LATENCY, 2, load access wait cycles; >=1.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
LSVLD  input  1  request valid
LREQ  input  1  load request qualifier
SREQ  input  1  store request qualifier
LSADDR  input  ADDR_SIZE  load/store word address
SDATA  input  DATA_SIZE  store data
LSRDY  output  1  responder can accept a request this cycle
LDATA  output  DATA_SIZE  load return data, registered
LDRDY  output  1  LDATA valid, one-cycle pulse per load
ERR  output  1  one-cycle pulse: illegal request dropped

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: LSRDY=1 (FIFO empty), LDATA=0, LDRDY=0, ERR=0, FSM=IDLE, FIFO pointers and count=0.
- Reset does not clear the RAM; RAM contents are preserved across rst.
- Accept condition: LSVLD & LSRDY at a rising edge.
  - Exactly one of LREQ/SREQ set: push {is_store, LSADDR, SDATA} into the FIFO.
  - Both set: no push; ERR=1 for the next cycle only.
  - Neither set: ignored, no ERR.
- LSRDY = (count != FIFO_DEPTH), decoded from registered count.
  - No push-through-when-full: LSRDY stays low when full, even in a cycle that pops.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT.
  - IDLE with FIFO non-empty: pop the head entry.
    - Store: RAM[addr] <= data on the pop edge; remain in IDLE, so one store per cycle.
    - Load: latch addr; cnt <= RD_LATENCY-1; go to WAIT.
  - IDLE with FIFO empty: no action.
  - WAIT, cnt != 0: cnt decrements.
  - WAIT, cnt == 0: on that edge LDATA <= RAM[latched addr], LDRDY <= 1, state <= IDLE.
  - RD_LATENCY=1: the load completes on the first WAIT edge.
- LDRDY is high for exactly one cycle per load. LDATA holds its value until the next load completes.
- Latency: with an empty FIFO and FSM in IDLE, LDRDY is high in the cycle after the edge that is RD_LATENCY+1 edges after the accepting edge.
- Throughput:
  - Stores: one per cycle.
  - Loads: one per RD_LATENCY+1 cycles; the next pop is on the edge after load completion.
- Ordering: strictly in order.
  - A store followed by a load to the same address returns the new data.
  - A load followed by a store to the same address returns the old data.
  - A RAM write and a RAM read never occur on the same edge.
- Reset mid-operation: FIFO flushed; an in-flight load is discarded and no LDRDY is ever produced for it; queued stores are not performed.
- Full address range is valid; there are no out-of-range errors.

Test Plan:
1. Assert rst for 2 cycles mid-traffic -> next cycle LSRDY=1, LDRDY=0, LDATA=0, ERR=0.
2. Store 0xBEEF to 0x10 at edge E0, load 0x10 at E1 (RD_LATENCY=2) -> single LDRDY pulse after E4, LDATA=0xBEEF.
3. Preload RAM[0..5]=0x0100+i, hold LSVLD with 6 back-to-back loads, FIFO_DEPTH=4:
   - LSRDY drops when count reaches 4; no request is lost.
   - 6 LDRDY pulses spaced 3 cycles apart return LDATA 0x0100..0x0105 in order.
4. LSVLD with LREQ=SREQ=1, LSADDR=0x10, SDATA=0x1234 -> ERR pulses one cycle, no LDRDY; a later load of 0x10 still returns 0xBEEF.
5. Accept a load of 0x10, assert rst on the next edge -> no LDRDY ever for it; a fresh load of 0x10 after reset returns 0xBEEF.
6. RD_LATENCY=1, store 0x00AA to 0xFF then load 0xFF (address wrap boundary) -> LDRDY 2 edges after the load accept, LDATA=0x00AA.
